bs_cat_sched: RTL and testbench

BS_CAT_SCHED -- requirements
Module: bs_cat_sched

---
 rtl/bs_pkg.sv | 18 +
 rtl/bs_cat_sched_if.sv | 59 +++++
 rtl/bs_len_mask.sv | 13 +
 rtl/bs_cat_sched.sv | 142 ++++++++++++++
 tb/tb_bs_cat_sched.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bs_pkg.sv
// Shared bitstream types and sizing for the concatenator scheduler family.
// Build option BS_CAT_SCHED_ALIGN_EN enables the word-align pad phase.
package bs_pkg;

    localparam int DATA_WD = 32;
    localparam int NUMB_WD = 5;
    localparam int MASK_WD = DATA_WD;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DAT   = 3'd2,
        S_TAL   = 3'd3,
        S_ALIGN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/bs_cat_sched_if.sv
// Stream control, three requester handshakes and the code output bus.
// Build option BS_CAT_SCHED_ALIGN_EN does not change this interface.
interface bs_cat_sched_if #(
    parameter int DATA_WD = bs_pkg::DATA_WD,
    parameter int NUMB_WD = bs_pkg::NUMB_WD
) ();

    logic               start_i;
    logic               busy_o;
    logic               done_o;

    logic               hdr_val_i;
    logic [DATA_WD-1:0] hdr_dat_i;
    logic [NUMB_WD-1:0] hdr_numb_i;
    logic               hdr_last_i;
    logic               hdr_rdy_o;

    logic               dat_val_i;
    logic [DATA_WD-1:0] dat_dat_i;
    logic [NUMB_WD-1:0] dat_numb_i;
    logic               dat_last_i;
    logic               dat_rdy_o;

    logic               tal_val_i;
    logic [DATA_WD-1:0] tal_dat_i;
    logic [NUMB_WD-1:0] tal_numb_i;
    logic               tal_last_i;
    logic               tal_rdy_o;

    logic               val_o;
    logic [DATA_WD-1:0] dat_o;
    logic [NUMB_WD-1:0] numb_o;
    logic [31:0]        bit_cnt_o;

    modport master (
        output start_i,
        input  busy_o, done_o,
        output hdr_val_i, hdr_dat_i, hdr_numb_i, hdr_last_i,
        input  hdr_rdy_o,
        output dat_val_i, dat_dat_i, dat_numb_i, dat_last_i,
        input  dat_rdy_o,
        output tal_val_i, tal_dat_i, tal_numb_i, tal_last_i,
        input  tal_rdy_o,
        input  val_o, dat_o, numb_o, bit_cnt_o
    );

    modport slave (
        input  start_i,
        output busy_o, done_o,
        input  hdr_val_i, hdr_dat_i, hdr_numb_i, hdr_last_i,
        output hdr_rdy_o,
        input  dat_val_i, dat_dat_i, dat_numb_i, dat_last_i,
        output dat_rdy_o,
        input  tal_val_i, tal_dat_i, tal_numb_i, tal_last_i,
        output tal_rdy_o,
        output val_o, dat_o, numb_o, bit_cnt_o
    );

endinterface

// File: rtl/bs_len_mask.sv
// Code length (length-1 encoding) to right-aligned bit mask.
// Independent of BS_CAT_SCHED_ALIGN_EN.
module bs_len_mask #(
    parameter int MASK_WD = bs_pkg::MASK_WD,
    parameter int NUMB_WD = bs_pkg::NUMB_WD
) (
    input  logic [NUMB_WD-1:0] i_numb,
    output logic [MASK_WD-1:0] o_mask
);

    assign o_mask = {MASK_WD{1'b1}} >> (MASK_WD - 1 - int'(i_numb));

endmodule

// File: rtl/bs_cat_sched.sv
// Header/data/tail code scheduler feeding an OR-based bit concatenator.
// Define BS_CAT_SCHED_ALIGN_EN to pad each stream to a word boundary.
module bs_cat_sched #(
    parameter int DATA_WD = bs_pkg::DATA_WD,
    parameter int NUMB_WD = bs_pkg::NUMB_WD
) (
    input  logic          clk,
    input  logic          rstn,
    bs_cat_sched_if.slave bus
);

    import bs_pkg::*;

    state_t             r_state;
    state_t             w_nxt;
    logic               r_val;
    logic [DATA_WD-1:0] r_dat;
    logic [NUMB_WD-1:0] r_numb;
    logic [31:0]        r_cnt;

    logic               w_sel_val;
    logic [DATA_WD-1:0] w_sel_dat;
    logic [NUMB_WD-1:0] w_sel_numb;
    logic               w_sel_last;
    logic [DATA_WD-1:0] w_mask;
    logic               w_emit;
    logic [DATA_WD-1:0] w_e_dat;
    logic [NUMB_WD-1:0] w_e_numb;

    assign bus.hdr_rdy_o = (r_state == S_HDR);
    assign bus.dat_rdy_o = (r_state == S_DAT);
    assign bus.tal_rdy_o = (r_state == S_TAL);

    always_comb begin
        w_sel_val  = 1'b0;
        w_sel_dat  = '0;
        w_sel_numb = '0;
        w_sel_last = 1'b0;
        unique case (r_state)
            S_HDR: begin
                w_sel_val  = bus.hdr_val_i;
                w_sel_dat  = bus.hdr_dat_i;
                w_sel_numb = bus.hdr_numb_i;
                w_sel_last = bus.hdr_last_i;
            end
            S_DAT: begin
                w_sel_val  = bus.dat_val_i;
                w_sel_dat  = bus.dat_dat_i;
                w_sel_numb = bus.dat_numb_i;
                w_sel_last = bus.dat_last_i;
            end
            S_TAL: begin
                w_sel_val  = bus.tal_val_i;
                w_sel_dat  = bus.tal_dat_i;
                w_sel_numb = bus.tal_numb_i;
                w_sel_last = bus.tal_last_i;
            end
            default: ;
        endcase
    end

    bs_len_mask #(
        .MASK_WD (DATA_WD),
        .NUMB_WD (NUMB_WD)
    ) u_mask (
        .i_numb (w_sel_numb),
        .o_mask (w_mask)
    );

`ifdef BS_CAT_SCHED_ALIGN_EN
    // Mirrors the concatenator fill level so the pad closes the word exactly
    logic [NUMB_WD-1:0] r_ptr;
    logic               w_pad;
    logic [NUMB_WD-1:0] w_pad_numb;

    assign w_pad      = (r_state == S_ALIGN) && (r_ptr != '0);
    assign w_pad_numb = NUMB_WD'(DATA_WD - 1) - r_ptr;
    assign w_emit     = w_sel_val | w_pad;
    assign w_e_dat    = w_pad ? '0 : (w_sel_dat & w_mask);
    assign w_e_numb   = w_pad ? w_pad_numb : w_sel_numb;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_ptr <= '0;
        end else if (w_emit) begin
            r_ptr <= r_ptr + w_e_numb + NUMB_WD'(1);
        end
    end
`else
    assign w_emit   = w_sel_val;
    assign w_e_dat  = w_sel_dat & w_mask;
    assign w_e_numb = w_sel_numb;
`endif

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start_i) w_nxt = S_HDR;
            S_HDR:   if (w_sel_val && w_sel_last) w_nxt = S_DAT;
            S_DAT:   if (w_sel_val && w_sel_last) w_nxt = S_TAL;
`ifdef BS_CAT_SCHED_ALIGN_EN
            S_TAL:   if (w_sel_val && w_sel_last) w_nxt = S_ALIGN;
            S_ALIGN: w_nxt = S_DONE;
`else
            S_TAL:   if (w_sel_val && w_sel_last) w_nxt = S_DONE;
`endif
            // Hold off done until the final beat has been presented
            S_DONE:  if (!r_val) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= S_IDLE;
            r_val   <= 1'b0;
            r_dat   <= '0;
            r_numb  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            r_val   <= w_emit;
            if (w_emit) begin
                r_dat  <= w_e_dat;
                r_numb <= w_e_numb;
            end
            if ((r_state == S_IDLE) && bus.start_i) begin
                r_cnt <= '0;
            end else if (w_emit) begin
                r_cnt <= r_cnt + 32'(w_e_numb) + 32'd1;
            end
        end
    end

    assign bus.val_o     = r_val;
    assign bus.dat_o     = r_dat;
    assign bus.numb_o    = r_numb;
    assign bus.bit_cnt_o = r_cnt;
    assign bus.busy_o    = (r_state != S_IDLE);
    assign bus.done_o    = (r_state == S_DONE) && !r_val;

endmodule

// File: tb/tb_bs_cat_sched.sv
// Scoreboard bench for bs_cat_sched: directed and random streams.
// Expected pad behaviour follows BS_CAT_SCHED_ALIGN_EN.
module tb_bs_cat_sched;

    logic clk = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    bs_cat_sched_if #(.DATA_WD(32), .NUMB_WD(5)) bus ();

    bs_cat_sched #(.DATA_WD(32), .NUMB_WD(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

`ifdef BS_CAT_SCHED_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic [31:0] dat;
        logic [4:0]  numb;
        logic [31:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   total = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_mask(logic [31:0] d, int n);
        logic [63:0] m;
        m = (64'd1 << (n + 1)) - 64'd1;
        return d & m[31:0];
    endfunction

    always @(negedge clk) begin
        if (bus.val_o === 1'b1) begin
            chk("beat_queued", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("dat_o", bus.dat_o, e.dat);
                chk("numb_o", 32'(bus.numb_o), 32'(e.numb));
                chk("bit_cnt_o", bus.bit_cnt_o, e.cnt);
            end
        end
    end

    task automatic idle_inputs();
        bus.start_i = 1'b0;
        bus.hdr_val_i = 1'b0; bus.hdr_dat_i = '0; bus.hdr_numb_i = '0; bus.hdr_last_i = 1'b0;
        bus.dat_val_i = 1'b0; bus.dat_dat_i = '0; bus.dat_numb_i = '0; bus.dat_last_i = 1'b0;
        bus.tal_val_i = 1'b0; bus.tal_dat_i = '0; bus.tal_numb_i = '0; bus.tal_last_i = 1'b0;
    endtask

    function automatic logic rdy_of(int ph);
        case (ph)
            0: return bus.hdr_rdy_o;
            1: return bus.dat_rdy_o;
            default: return bus.tal_rdy_o;
        endcase
    endfunction

    task automatic drive(int ph, logic v, logic [31:0] d, int n, logic last);
        case (ph)
            0: begin
                bus.hdr_val_i = v; bus.hdr_dat_i = d;
                bus.hdr_numb_i = 5'(n); bus.hdr_last_i = last;
            end
            1: begin
                bus.dat_val_i = v; bus.dat_dat_i = d;
                bus.dat_numb_i = 5'(n); bus.dat_last_i = last;
            end
            default: begin
                bus.tal_val_i = v; bus.tal_dat_i = d;
                bus.tal_numb_i = 5'(n); bus.tal_last_i = last;
            end
        endcase
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        total = 0;
        chk("busy_after_start", 32'(bus.busy_o), 32'd1);
    endtask

    // Called and returns on a falling edge
    task automatic beat(int ph, logic [31:0] d, int n, logic last, bit gaps);
        bit ok;
        ok = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        drive(ph, 1'b1, d, n, last);
        for (int i = 0; i < 50; i++) begin
            if (rdy_of(ph) === 1'b1) begin
                chk("rdy_onehot",
                    32'(bus.hdr_rdy_o) + 32'(bus.dat_rdy_o) + 32'(bus.tal_rdy_o), 32'd1);
                total += n + 1;
                sbq.push_back('{ref_mask(d, n), 5'(n), 32'(total)});
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        drive(ph, 1'b0, $urandom, int'($urandom_range(0, 31)), 1'b0);
        chk("beat_accepted", 32'(ok), 32'd1);
    endtask

    task automatic finish_stream();
        bit   got;
        logic pv;
        int   pn;
        got = 1'b0;
        if (ALIGN && (total % 32) != 0) begin
            pn = 31 - (total % 32);
            total += pn + 1;
            sbq.push_back('{32'd0, 5'(pn), 32'(total)});
        end
        pv = bus.val_o;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            pv = bus.val_o;
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("done_after_last_val", 32'(pv), 32'd1);
        chk("bit_cnt_final", bus.bit_cnt_o, 32'(total));
        chk("sb_empty_at_done", 32'(sbq.size()), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done_o), 32'd0);
        chk("busy_cleared", 32'(bus.busy_o), 32'd0);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_val"}, 32'(bus.val_o), 32'd0);
        chk({tag, "_dat"}, bus.dat_o, 32'd0);
        chk({tag, "_numb"}, 32'(bus.numb_o), 32'd0);
        chk({tag, "_bitcnt"}, bus.bit_cnt_o, 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
        chk({tag, "_rdy"},
            {29'd0, bus.hdr_rdy_o, bus.dat_rdy_o, bus.tal_rdy_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        // 64-bit stream: word aligned, no pad
        do_start();
        beat(0, $urandom, 7, 1'b1, 1'b0);
        beat(1, $urandom, 15, 1'b0, 1'b0);
        beat(1, $urandom, 31, 1'b1, 1'b0);
        beat(2, $urandom, 7, 1'b1, 1'b0);
        finish_stream();
        chk("t64_bit_cnt", bus.bit_cnt_o, 32'd64);

        // 70-bit stream: pad numb 25 when aligning
        do_start();
        beat(0, $urandom, 7, 1'b1, 1'b0);
        beat(1, $urandom, 31, 1'b0, 1'b0);
        beat(1, $urandom, 21, 1'b1, 1'b0);
        beat(2, $urandom, 7, 1'b1, 1'b0);
        finish_stream();
        chk("t70_bit_cnt", bus.bit_cnt_o, ALIGN ? 32'd96 : 32'd70);

        // Non-granted requester ignored; masking of high bits
        do_start();
        bus.dat_val_i = 1'b1;
        bus.dat_dat_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            chk("hdr_phase_dat_rdy", 32'(bus.dat_rdy_o), 32'd0);
            chk("hdr_phase_no_val", 32'(bus.val_o), 32'd0);
            @(negedge clk);
        end
        bus.dat_val_i = 1'b0;
        beat(0, 32'hFFFF_FFFF, 3, 1'b1, 1'b0);
        chk("mask_dat_o", bus.dat_o, 32'h0000_000F);
        beat(1, $urandom, 11, 1'b1, 1'b0);
        beat(2, $urandom, 4, 1'b1, 1'b0);
        finish_stream();

        // start_i in DAT has no effect
        do_start();
        beat(0, $urandom, 9, 1'b1, 1'b0);
        beat(1, $urandom, 20, 1'b0, 1'b0);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("midstart_bit_cnt", bus.bit_cnt_o, 32'(total));
        chk("midstart_dat_rdy", 32'(bus.dat_rdy_o), 32'd1);
        beat(1, $urandom, 5, 1'b1, 1'b0);
        beat(2, $urandom, 2, 1'b1, 1'b0);
        finish_stream();

        // Reset in DAT drops the stream
        do_start();
        beat(0, $urandom, 6, 1'b1, 1'b0);
        beat(1, $urandom, 13, 1'b0, 1'b0);
        beat(1, $urandom, 17, 1'b0, 1'b0);
        #1;
        rstn = 1'b1;
        #1;
        chk_all_zero("midrst");
        sbq.delete();
        idle_inputs();
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_rst_no_done", 32'(bus.done_o), 32'd0);
            chk("after_rst_no_val", 32'(bus.val_o), 32'd0);
        end
        do_start();
        chk("restart_bit_cnt", bus.bit_cnt_o, 32'd0);
        beat(0, $urandom, 3, 1'b1, 1'b0);
        beat(1, $urandom, 8, 1'b1, 1'b0);
        beat(2, $urandom, 1, 1'b1, 1'b0);
        finish_stream();

        // Random streams with random gaps
        for (int s = 0; s < 8; s++) begin
            int nh, nd, nt;
            nh = $urandom_range(1, 2);
            nd = $urandom_range(1, 4);
            nt = $urandom_range(1, 2);
            do_start();
            for (int b = 0; b < nh; b++)
                beat(0, $urandom, $urandom_range(0, 31), b == nh - 1, 1'b1);
            for (int b = 0; b < nd; b++)
                beat(1, $urandom, $urandom_range(0, 31), b == nd - 1, 1'b1);
            for (int b = 0; b < nt; b++)
                beat(2, $urandom, $urandom_range(0, 31), b == nt - 1, 1'b1);
            finish_stream();
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
